// File: rtl/isram_responder.sv
// Instruction-SRAM responder: accepts word-read requests, waits a configurable
// (optionally randomised) latency, then returns the word with a one-cycle ready pulse.
module isram_responder #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4096,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    LATENCY    = 2,
    parameter bit                    RAND_DELAY = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  isram_req,
    input  logic [DATA_WIDTH-1:0] isram_raddr,
    output logic [DATA_WIDTH-1:0] isram_rdata,
    output logic                  isram_ready,
    output logic                  isram_err,
    output logic                  isram_busy,
    input  logic                  pl_wen,
    input  logic [DATA_WIDTH-1:0] pl_waddr,
    input  logic [DATA_WIDTH-1:0] pl_wdata
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 4);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                  state_reg;
    logic [DATA_WIDTH-1:0]   addr_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic [7:0]              lfsr_reg;
    logic [DATA_WIDTH-1:0]   rdata_reg;
    logic                    ready_reg;
    logic                    err_reg;
    logic                    busy_reg;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [7:0]              lfsr_next;
    logic [1:0]              extra;
    logic [CNT_W-1:0]        load_cnt;
    logic [DATA_WIDTH-1:0]   resp_data;

    // Decoder slot 0 serves the read path, slot 1 the preload path.
    logic [DATA_WIDTH-1:0]   dec_addr  [2];
    logic [DATA_WIDTH-1:0]   dec_off   [2];
    logic                    dec_fault [2];
    logic [IDX_W-1:0]        dec_idx   [2];

    // While waiting, the latched address is used; otherwise the live request address.
    assign dec_addr[0] = (state_reg == ST_WAIT) ? addr_reg : isram_raddr;
    assign dec_addr[1] = pl_waddr;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_decode
            assign dec_off[gi]   = dec_addr[gi] - BASE_ADDR;
            assign dec_fault[gi] = (|dec_addr[gi][1:0])
                                 || (dec_addr[gi] < BASE_ADDR)
                                 || ((dec_off[gi] >> 2) >= DATA_WIDTH'(DEPTH));
            assign dec_idx[gi]   = dec_off[gi][IDX_W+1:2];
        end
    endgenerate

    // Fibonacci LFSR, taps 8,6,5,4; nonzero seed keeps it out of the all-zero state.
    assign lfsr_next = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
    assign extra     = RAND_DELAY ? lfsr_reg[1:0] : 2'b00;
    assign load_cnt  = CNT_W'(LATENCY - 1) + CNT_W'(extra);
    assign resp_data = dec_fault[0] ? '0 : mem[dec_idx[0]];

    always_ff @(posedge clk) begin
        if (pl_wen && !dec_fault[1]) begin
            mem[dec_idx[1]] <= pl_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            cnt_reg   <= '0;
            lfsr_reg  <= 8'hA5;
            rdata_reg <= '0;
            ready_reg <= 1'b0;
            err_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            ready_reg <= 1'b0;
            err_reg   <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_RESP: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                    if (isram_req) begin
                        addr_reg <= isram_raddr;
                        if (RAND_DELAY) begin
                            lfsr_reg <= lfsr_next;
                        end
                        if (load_cnt == '0) begin
                            state_reg <= ST_RESP;
                            ready_reg <= 1'b1;
                            err_reg   <= dec_fault[0];
                            rdata_reg <= resp_data;
                            cnt_reg   <= '0;
                        end else begin
                            state_reg <= ST_WAIT;
                            busy_reg  <= 1'b1;
                            cnt_reg   <= load_cnt;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg <= ST_RESP;
                        busy_reg  <= 1'b0;
                        ready_reg <= 1'b1;
                        err_reg   <= dec_fault[0];
                        rdata_reg <= resp_data;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign isram_rdata = rdata_reg;
    assign isram_ready = ready_reg;
    assign isram_err   = err_reg;
    assign isram_busy  = busy_reg;

endmodule

// File: tb/tb_isram_responder.sv
// Directed bench for isram_responder: fixed-latency instance plus a
// LATENCY=1 / RAND_DELAY=1 instance checked against a reference LFSR.
module tb_isram_responder;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          DEP  = 4096;

    logic        clk;
    logic        rst;
    logic        req,   req_r;
    logic [31:0] raddr, raddr_r;
    logic [31:0] rdata, rdata_r;
    logic        ready, ready_r;
    logic        err,   err_r;
    logic        busy,  busy_r;
    logic        pl_wen;
    logic [31:0] pl_waddr;
    logic [31:0] pl_wdata;

    int vectors;
    int miscompares;

    isram_responder #(.DATA_WIDTH(32), .DEPTH(DEP), .BASE_ADDR(BASE), .LATENCY(2), .RAND_DELAY(1'b0)) dut (
        .clk(clk), .rst(rst), .isram_req(req), .isram_raddr(raddr),
        .isram_rdata(rdata), .isram_ready(ready), .isram_err(err), .isram_busy(busy),
        .pl_wen(pl_wen), .pl_waddr(pl_waddr), .pl_wdata(pl_wdata)
    );

    isram_responder #(.DATA_WIDTH(32), .DEPTH(DEP), .BASE_ADDR(BASE), .LATENCY(1), .RAND_DELAY(1'b1)) dut_r (
        .clk(clk), .rst(rst), .isram_req(req_r), .isram_raddr(raddr_r),
        .isram_rdata(rdata_r), .isram_ready(ready_r), .isram_err(err_r), .isram_busy(busy_r),
        .pl_wen(pl_wen), .pl_waddr(pl_waddr), .pl_wdata(pl_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word_val(input int i);
        if (i == 0) return 32'h0000_0413;
        if (i == 1) return 32'h0010_0093;
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({ready, err, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: got ready/err/busy=%b required 000", {ready, err, busy});
        end
        vectors++;
        if (rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rdata: got %h required 00000000", rdata);
        end
        vectors++;
        if ({ready_r, busy_r, rdata_r} !== 34'h0) begin
            miscompares++;
            $display("FAIL reset_rand: got ready=%b busy=%b rdata=%h required 0/0/0", ready_r, busy_r, rdata_r);
        end
        rst = 1'b1;
        step();
        $display("reset done");
    endtask

    task automatic preload();
        for (int i = 0; i < 18; i++) begin
            pl_wen   = 1'b1;
            pl_waddr = BASE + 32'(4 * i);
            pl_wdata = word_val(i);
            step();
        end
        // Out-of-range preload must not alias onto word 0.
        pl_waddr = BASE + 32'(4 * DEP);
        pl_wdata = 32'hDEAD_BEEF;
        step();
        pl_wen = 1'b0;
        $display("preload: 18 words written, 1 out-of-range write issued");
    endtask

    task automatic test_single_read();
        req = 1'b1; raddr = BASE;
        step();
        req = 1'b0;
        vectors++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
            miscompares++;
            $display("FAIL t1_wait: got busy=%b ready=%b required busy=1 ready=0", busy, ready);
        end
        step();
        vectors++;
        if (ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL t1_ready: got ready=%b busy=%b required ready=1 busy=0", ready, busy);
        end
        vectors++;
        if (rdata !== 32'h0000_0413 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL t1_data: got rdata=%h err=%b required 00000413/0", rdata, err);
        end
        step();
        vectors++;
        if (ready !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL t1_idle: got ready=%b busy=%b required 0/0", ready, busy);
        end
        $display("t1 read %h -> %h err=%b", BASE, rdata, err);
    endtask

    task automatic test_back_to_back();
        req = 1'b1; raddr = BASE;
        step();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL t2_busy0: got %b required 1", busy);
        end
        step();
        vectors++;
        if (ready !== 1'b1 || rdata !== 32'h0000_0413) begin
            miscompares++;
            $display("FAIL t2_resp0: got ready=%b rdata=%h required 1/00000413", ready, rdata);
        end
        raddr = BASE + 32'd4;
        step();
        vectors++;
        if (ready !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL t2_accept1: got ready=%b busy=%b required 0/1", ready, busy);
        end
        req = 1'b0;
        step();
        vectors++;
        if (ready !== 1'b1 || rdata !== 32'h0010_0093 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL t2_resp1: got ready=%b rdata=%h err=%b required 1/00100093/0", ready, rdata, err);
        end
        step();
        vectors++;
        if (ready !== 1'b0) begin
            miscompares++;
            $display("FAIL t2_end: got ready=%b required 0", ready);
        end
        $display("t2 back-to-back done");
    endtask

    task automatic test_faults();
        logic [31:0] addrs [3];
        addrs[0] = 32'h8000_0002;
        addrs[1] = 32'h7FFF_FFFC;
        addrs[2] = BASE + 32'(4 * DEP);
        for (int i = 0; i < 3; i++) begin
            req = 1'b1; raddr = addrs[i];
            step();
            req = 1'b0;
            vectors++;
            if (ready !== 1'b0) begin
                miscompares++;
                $display("FAIL t3_early[%0d]: got ready=%b required 0", i, ready);
            end
            step();
            vectors++;
            if (ready !== 1'b1 || err !== 1'b1 || rdata !== 32'h0) begin
                miscompares++;
                $display("FAIL t3_fault[%0d]: got ready=%b err=%b rdata=%h required 1/1/00000000", i, ready, err, rdata);
            end
            $display("t3 read %h -> err=%b rdata=%h", addrs[i], err, rdata);
            step();
            vectors++;
            if (err !== 1'b0) begin
                miscompares++;
                $display("FAIL t3_errclr[%0d]: got err=%b required 0", i, err);
            end
        end
    endtask

    task automatic test_addr_change_in_wait();
        req = 1'b1; raddr = BASE;
        step();
        req = 1'b0; raddr = BASE + 32'd4;
        step();
        vectors++;
        if (ready !== 1'b1 || rdata !== 32'h0000_0413) begin
            miscompares++;
            $display("FAIL t4_latched: got ready=%b rdata=%h required 1/00000413", ready, rdata);
        end
        step();
        $display("t4 latched read -> %h", rdata);
    endtask

    task automatic test_mid_reset();
        req = 1'b1; raddr = BASE;
        step();
        req = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL t5_prebusy: got %b required 1", busy);
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({ready, busy} !== 2'b00 || rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL t5_async: got ready=%b busy=%b rdata=%h required 0/0/00000000", ready, busy, rdata);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (ready !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL t5_noresp[%0d]: got ready=%b busy=%b required 0/0", i, ready, busy);
            end
        end
        $display("t5 mid-request reset done");
    endtask

    task automatic test_rand_delay();
        logic [7:0] ref_lfsr;
        int         exp_delay;
        int         k;
        ref_lfsr = 8'hA5;
        req_r    = 1'b1;
        raddr_r  = BASE + 32'd8;
        for (int i = 0; i < 16; i++) begin
            step();
            exp_delay = int'(ref_lfsr[1:0]) + 1;
            ref_lfsr  = {ref_lfsr[6:0], ref_lfsr[7] ^ ref_lfsr[5] ^ ref_lfsr[4] ^ ref_lfsr[3]};
            k = 1;
            while (ready_r !== 1'b1 && k < 8) begin
                step();
                k++;
            end
            vectors++;
            if (k !== exp_delay) begin
                miscompares++;
                $display("FAIL t6_delay[%0d]: got %0d cycles required %0d", i, k, exp_delay);
            end
            vectors++;
            if (rdata_r !== word_val(i + 2) || err_r !== 1'b0) begin
                miscompares++;
                $display("FAIL t6_data[%0d]: got rdata=%h err=%b required %h/0", i, rdata_r, err_r, word_val(i + 2));
            end
            $display("t6 req %0d addr %h delay %0d rdata %h", i, raddr_r, k, rdata_r);
            if (i == 15) req_r = 1'b0;
            else raddr_r = BASE + 32'(4 * (i + 3));
        end
        step();
        vectors++;
        if (ready_r !== 1'b0 || busy_r !== 1'b0) begin
            miscompares++;
            $display("FAIL t6_end: got ready=%b busy=%b required 0/0", ready_r, busy_r);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        req = 1'b0; raddr = '0;
        req_r = 1'b0; raddr_r = '0;
        pl_wen = 1'b0; pl_waddr = '0; pl_wdata = '0;
        test_reset();
        preload();
        test_single_read();
        test_back_to_back();
        test_faults();
        test_addr_change_in_wait();
        test_mid_reset();
        test_rand_delay();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/isram_responder.md
Name: isram_responder

Overview:
- Instruction-SRAM responder: the memory side of the instruction-fetch read interface.
- Accepts a word-read request (address plus request strobe) and counts a configurable access latency. It then returns the instruction word with a one-cycle ready pulse.
- Sits between the fetch unit and the instruction memory array. It replaces the zero-latency behavioural model so that fetch stalls are exercised.
- Includes a preload write port so benches and loaders can fill the program image.

Parameters:
- DATA_WIDTH, 32, data and address width.
- DEPTH, 4096, number of 32-bit words in the array.
- BASE_ADDR, 32'h8000_0000, byte address mapped to word 0.
- LATENCY, 2, base cycles from request acceptance to the ready pulse. Legal values are ≥1.
- RAND_DELAY, 0, when 1, adds 0..3 extra wait cycles taken from an internal LFSR.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- isram_req  in  1  read request strobe from fetch.
- isram_raddr  in  DATA_WIDTH  byte address of the requested instruction.
- isram_rdata  out  DATA_WIDTH  returned instruction word.
- isram_ready  out  1  one-cycle pulse; isram_rdata and isram_err are valid in this cycle.
- isram_err  out  1  access fault (misaligned or out of range), qualified by isram_ready.
- isram_busy  out  1  high while a request is outstanding (WAIT state).
- pl_wen  in  1  preload write enable.
- pl_waddr  in  DATA_WIDTH  preload byte address; word-aligned, in range.
- pl_wdata  in  DATA_WIDTH  preload data.

Behaviour:
- Reset (rst low, asynchronous):
  - state becomes IDLE.
  - isram_ready, isram_err and isram_busy become 0; isram_rdata becomes 0.
  - Latched address and counter are cleared; LFSR loads 8'hA5.
  - Memory contents are not reset.
- Reset mid-request: the request is discarded, and no ready pulse follows the release of reset.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - If isram_req is high, latch isram_raddr and load cnt = LATENCY-1 + extra.
  - extra is 0 when RAND_DELAY=0; otherwise extra = lfsr[1:0], and the LFSR advances on each acceptance.
  - If the loaded count is 0, go to RESP; otherwise go to WAIT.
- WAIT:
  - isram_busy=1. Decrement cnt each cycle, and go to RESP when cnt reaches 0.
  - isram_req and isram_raddr are ignored while in WAIT; a changed address does not restart the access.
- RESP (exactly one cycle):
  - isram_ready=1. isram_rdata and isram_err are registered on the edge entering RESP.
  - If isram_req is high in RESP, the new request is accepted as from IDLE (back-to-back). Otherwise go to IDLE.
- Latency:
  - Request sampled at edge t gives isram_ready high in the cycle after edge t+LATENCY-1+extra.
  - With LATENCY=1, ready appears in the cycle immediately after acceptance.
- Outputs outside RESP: isram_ready=0, isram_err=0. isram_rdata holds its last value (it is not cleared).
- Address decode:
  - word index = (addr - BASE_ADDR) >> 2.
  - If addr[1:0] is nonzero, or addr < BASE_ADDR, or index ≥ DEPTH, then isram_err=1 and isram_rdata=0. The fault is reported with the same latency as a normal access.
- Subtraction is done at DATA_WIDTH with wrap-around. An address below base underflows to a large index and faults through the range check.
- Preload:
  - When pl_wen is high, write at the edge regardless of FSM state.
  - An out-of-range or misaligned preload address is silently dropped.
  - Read/write collision on the same word at the same edge (the edge entering RESP): rdata returns the old word.
- LFSR: 8-bit Fibonacci LFSR, taps 8,6,5,4. It never reaches zero.

Test Plan:
1. Preload 0x80000000=0x00000413, 0x80000004=0x00100093. With LATENCY=2, pulse req with addr 0x80000000 → ready pulses in the 2nd cycle after acceptance, rdata=0x00000413, err=0, busy high for 1 cycle.
2. Hold req high continuously over addresses 0x80000000 then 0x80000004 (the address is changed in the RESP cycle) → two ready pulses LATENCY cycles apart, rdata 0x00000413 then 0x00100093, no idle gap.
3. Request addr 0x80000002, then addr 0x7FFFFFFC, then addr BASE+4*DEPTH → each returns ready with err=1 and rdata=0 after the normal latency.
4. During WAIT, change raddr to 0x80000004 → response still returns data for the originally latched 0x80000000.
5. Drive rst low for one cycle in the middle of WAIT → ready, busy and rdata become 0 immediately. After rst goes high, no ready pulse appears until a new req.
6. With RAND_DELAY=1 and LATENCY=1, issue 16 back-to-back requests → each ready comes 1–4 cycles after acceptance, the delay sequence matches a reference LFSR seeded 0xA5, and all data is correct.
